// File: rtl/vec_pipe_if.sv
// Valid/ready vector bus between a producer, vec_pipe_reg and a consumer.
// master drives the input side and consumes the output side.
interface vec_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic                          in_valid;
  logic                          in_ready;
  logic [0:DEPTH-1][WIDTH-1:0]   in_data;
  logic [DEPTH-1:0]              in_mask;
  logic                          out_valid;
  logic                          out_ready;
  logic [0:DEPTH-1][WIDTH-1:0]   out_data;

  modport master (
    output in_valid,
    output in_data,
    output in_mask,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_mask,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/vec_pipe_reg.sv
// Masked vector pipeline register chain with valid/ready flow control.
// Define VEC_PIPE_REG_OCC_EN to add the registered occupancy output.
module vec_pipe_reg #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
`ifdef VEC_PIPE_REG_OCC_EN
  output logic [$clog2(STAGES+1)-1:0] occupancy,
`endif
  vec_pipe_if.slave bus
);

  typedef logic [0:DEPTH-1][WIDTH-1:0] vec_t;

  logic [STAGES-1:0] r_v;
  vec_t              r_d [STAGES];
  logic [STAGES-1:0] w_rdy;
  logic              w_in_xfer;

  // Ready chain: a stage accepts if it is empty or everything ahead can move.
  always_comb begin
    logic w_acc;
    w_acc = bus.out_ready;
    w_rdy = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      w_acc    = !r_v[s] || w_acc;
      w_rdy[s] = w_acc;
    end
  end

  assign bus.in_ready  = w_rdy[0] && !flush;
  assign w_in_xfer     = bus.in_valid && bus.in_ready;
  assign bus.out_valid = r_v[STAGES-1];
  assign bus.out_data  = r_d[STAGES-1];

  // Valid bits shift forward; flush empties the whole chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v <= '0;
    end else if (flush) begin
      r_v <= '0;
    end else begin
      if (w_rdy[0]) r_v[0] <= w_in_xfer;
      for (int s = 1; s < STAGES; s++) begin
        if (w_rdy[s]) r_v[s] <= r_v[s-1];
      end
    end
  end

  // Data moves only with a valid vector; stage 0 merges masked lanes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < STAGES; s++) r_d[s] <= '0;
    end else if (!flush) begin
      if (w_in_xfer) begin
        for (int l = 0; l < DEPTH; l++) begin
          if (bus.in_mask[l]) r_d[0][l] <= bus.in_data[l];
        end
      end
      for (int s = 1; s < STAGES; s++) begin
        if (w_rdy[s] && r_v[s-1]) r_d[s] <= r_d[s-1];
      end
    end
  end

`ifdef VEC_PIPE_REG_OCC_EN
  localparam int OW = $clog2(STAGES + 1);

  logic [OW-1:0] r_occ;
  logic          w_out_xfer;

  assign w_out_xfer = r_v[STAGES-1] && bus.out_ready;
  assign occupancy  = r_occ;

  // Occupancy tracks the number of set valid bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_occ <= r_occ + OW'(1);
    end else if (!w_in_xfer && w_out_xfer) begin
      r_occ <= r_occ - OW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vec_pipe_reg.sv
// Self-checking bench for vec_pipe_reg (WIDTH=8, DEPTH=4, STAGES=2).
// Reference is a queue of in-flight vectors with abstract positions.
module tb_vec_pipe_reg;
  localparam int W = 8;
  localparam int D = 4;
  localparam int S = 2;

  typedef logic [0:D-1][W-1:0] vec_t;
  typedef struct {
    vec_t d;
    int   p;
  } item_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  vec_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();

`ifdef VEC_PIPE_REG_OCC_EN
  logic [$clog2(S+1)-1:0] occupancy;
`endif

  vec_pipe_reg #(.WIDTH(W), .DEPTH(D), .STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
`ifdef VEC_PIPE_REG_OCC_EN
    .occupancy (occupancy),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  item_t q[$];
  vec_t  lastacc  = '0;

  function automatic vec_t mk(int b);
    vec_t v;
    for (int l = 0; l < D; l++) v[l] = W'(b + l);
    return v;
  endfunction

  // Advance one clock edge and move the reference along with it.
  task automatic tick();
    bit   ir;
    bit   ov;
    int   lim;
    vec_t nv;
    ir = !flush && (q.size() < S || bus.out_ready);
    ov = q.size() > 0 && q[0].p == S - 1;
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (ov && bus.out_ready) void'(q.pop_front());
      for (int i = 0; i < q.size(); i++) begin
        lim = (i == 0) ? S : q[i-1].p;
        if (q[i].p + 1 < lim) q[i].p = q[i].p + 1;
      end
      if (bus.in_valid && ir) begin
        nv = lastacc;
        for (int l = 0; l < D; l++)
          if (bus.in_mask[l]) nv[l] = bus.in_data[l];
        lastacc = nv;
        q.push_back('{d: nv, p: 0});
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b want=0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h want=0", bus.out_data);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b want=1", bus.in_ready);
    end
`ifdef VEC_PIPE_REG_OCC_EN
    checks++;
    if (occupancy !== '0) begin
      failures++;
      $display("FAIL reset_occ got=%0d want=0", occupancy);
    end
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release valid=%b ready=%b want 0/1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_stream();
    bus.out_ready = 1'b1;
    bus.in_mask   = 4'hF;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.in_data = mk(4 * k + 1);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_ready k=%0d got=%b want=1", k, bus.in_ready);
      end
      tick();
      checks++;
      if (k == 0) begin
        if (bus.out_valid !== 1'b0) begin
          failures++;
          $display("FAIL stream_lat got=%b want=0", bus.out_valid);
        end
      end else if (bus.out_valid !== 1'b1 ||
                   bus.out_data !== mk(4 * (k - 1) + 1)) begin
        failures++;
        $display("FAIL stream k=%0d valid=%b got=%h want=%h", k,
                 bus.out_valid, bus.out_data, mk(4 * (k - 1) + 1));
      end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== mk(21)) begin
      failures++;
      $display("FAIL stream_tail valid=%b got=%h want=%h",
               bus.out_valid, bus.out_data, mk(21));
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_empty got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mask   = 4'hF;
    bus.in_data   = mk(8'h10);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_rdy0 got=%b want=1", bus.in_ready);
    end
    tick();
    bus.in_data = mk(8'h20);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_rdy1 got=%b want=1", bus.in_ready);
    end
    tick();
    bus.in_data = mk(8'h30);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full got=%b want=0", bus.in_ready);
    end
`ifdef VEC_PIPE_REG_OCC_EN
    checks++;
    if (occupancy !== 2'd2) begin
      failures++;
      $display("FAIL bp_occ got=%0d want=2", occupancy);
    end
`endif
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== mk(8'h10)) begin
      failures++;
      $display("FAIL bp_hold valid=%b got=%h want=%h",
               bus.out_valid, bus.out_data, mk(8'h10));
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_chain got=%b want=1", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_data !== mk(8'h20)) begin
      failures++;
      $display("FAIL bp_out1 got=%h want=%h", bus.out_data, mk(8'h20));
    end
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== mk(8'h30)) begin
      failures++;
      $display("FAIL bp_out2 valid=%b got=%h want=%h",
               bus.out_valid, bus.out_data, mk(8'h30));
    end
    tick();
  endtask

  task automatic test_mask();
    vec_t a;
    vec_t b;
    vec_t e;
    a = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    b = {8'h11, 8'h22, 8'h33, 8'h44};
    e = {8'h11, 8'hBB, 8'h33, 8'hDD};
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = a;
    bus.in_mask   = 4'hF;
    tick();
    bus.in_data = b;
    bus.in_mask = 4'b0101;
    tick();
    checks++;
    if (bus.out_data !== a) begin
      failures++;
      $display("FAIL mask_first got=%h want=%h", bus.out_data, a);
    end
    bus.in_valid = 1'b0;
    bus.in_mask  = 4'hF;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
      failures++;
      $display("FAIL mask_merge valid=%b got=%h want=%h",
               bus.out_valid, bus.out_data, e);
    end
    tick();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mask   = 4'hF;
    bus.in_data   = mk(8'h40);
    tick();
    bus.in_data = mk(8'h50);
    tick();
    bus.in_data = mk(8'h58);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_block got=%b want=0", bus.in_ready);
    end
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_valid got=%b want=0", bus.out_valid);
    end
`ifdef VEC_PIPE_REG_OCC_EN
    checks++;
    if (occupancy !== '0) begin
      failures++;
      $display("FAIL flush_occ got=%0d want=0", occupancy);
    end
`endif
    bus.in_valid = 1'b1;
    bus.in_data  = mk(8'h60);
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_lat got=%b want=0", bus.out_valid);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== mk(8'h60)) begin
      failures++;
      $display("FAIL flush_next valid=%b got=%h want=%h",
               bus.out_valid, bus.out_data, mk(8'h60));
    end
    tick();
  endtask

  task automatic test_async_reset();
    vec_t e;
    e = {8'h90, 8'h00, 8'h00, 8'h00};
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mask   = 4'hF;
    bus.in_data   = mk(8'h70);
    tick();
    bus.in_data = mk(8'h80);
    tick();
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
      failures++;
      $display("FAIL arst_out valid=%b data=%h want 0/0",
               bus.out_valid, bus.out_data);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL arst_ready got=%b want=1", bus.in_ready);
    end
`ifdef VEC_PIPE_REG_OCC_EN
    checks++;
    if (occupancy !== '0) begin
      failures++;
      $display("FAIL arst_occ got=%0d want=0", occupancy);
    end
`endif
    q.delete();
    lastacc = '0;
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_mask   = 4'b0001;
    bus.in_data   = mk(8'h90);
    tick();
    bus.in_valid = 1'b0;
    bus.in_mask  = 4'hF;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
      failures++;
      $display("FAIL arst_lanes valid=%b got=%h want=%h",
               bus.out_valid, bus.out_data, e);
    end
    tick();
  endtask

  task automatic test_random();
    bit   eir;
    bit   eov;
    vec_t v;
    for (int n = 0; n < 400; n++) begin
      for (int l = 0; l < D; l++) v[l] = W'($urandom);
      bus.in_data   = v;
      bus.in_mask   = D'($urandom);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 15) == 0);
      #1;
      eir = !flush && (q.size() < S || bus.out_ready);
      eov = q.size() > 0 && q[0].p == S - 1;
      checks++;
      if (bus.in_ready !== eir) begin
        failures++;
        $display("FAIL rnd_ready n=%0d got=%b want=%b", n, bus.in_ready, eir);
      end
      checks++;
      if (bus.out_valid !== eov) begin
        failures++;
        $display("FAIL rnd_valid n=%0d got=%b want=%b", n, bus.out_valid, eov);
      end
      if (eov) begin
        checks++;
        if (bus.out_data !== q[0].d) begin
          failures++;
          $display("FAIL rnd_data n=%0d got=%h want=%h",
                   n, bus.out_data, q[0].d);
        end
      end
`ifdef VEC_PIPE_REG_OCC_EN
      checks++;
      if (int'(occupancy) != q.size()) begin
        failures++;
        $display("FAIL rnd_occ n=%0d got=%0d want=%0d",
                 n, occupancy, q.size());
      end
`endif
      tick();
    end
    flush        = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mask   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_mask();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
